// File: rtl/uart_tx_seq_if.sv
// Handshake bundle between uart_tx_seq, the TX FIFO and the transmitter.
// i_cts_n exists only when UART_TX_SEQ_FLOW_CTRL_EN is defined.
interface uart_tx_seq_if #(
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned CountWidth = 16
);
  logic                  i_en;
  logic                  i_fifo_empty;
  logic [DataWidth-1:0]  i_fifo_rd_data;
  logic                  o_fifo_rd_en;
  logic                  o_tx_valid;
  logic [DataWidth-1:0]  o_tx_data;
  logic                  i_tx_ready;
  logic                  o_busy;
  logic [CountWidth-1:0] o_tx_count;
`ifdef UART_TX_SEQ_FLOW_CTRL_EN
  logic                  i_cts_n;
`endif

  modport master (
    input  i_en, i_fifo_empty, i_fifo_rd_data, i_tx_ready,
`ifdef UART_TX_SEQ_FLOW_CTRL_EN
    input  i_cts_n,
`endif
    output o_fifo_rd_en, o_tx_valid, o_tx_data, o_busy, o_tx_count
  );

  modport slave (
    output i_en, i_fifo_empty, i_fifo_rd_data, i_tx_ready,
`ifdef UART_TX_SEQ_FLOW_CTRL_EN
    output i_cts_n,
`endif
    input  o_fifo_rd_en, o_tx_valid, o_tx_data, o_busy, o_tx_count
  );
endinterface

// File: rtl/uart_tx_seq.sv
// TX sequencer: pops one FIFO byte, offers it over valid/ready, then idles GapCycles.
// Optional CTS gating of the pop: define UART_TX_SEQ_FLOW_CTRL_EN.
module uart_tx_seq #(
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned GapCycles  = 0,
  parameter int unsigned CountWidth = 16
) (
  input logic           i_clk,
  input logic           i_rst_n,
  uart_tx_seq_if.master bus
);
  localparam int unsigned GapWidth = (GapCycles > 0) ? $clog2(GapCycles + 1) : 1;
  localparam int unsigned GapLoad  = (GapCycles > 0) ? GapCycles - 1 : 0;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e                state_q;
  logic [DataWidth-1:0]  data_q;
  logic                  valid_q;
  logic                  busy_q;
  logic [CountWidth-1:0] count_q;
  logic [CountWidth-1:0] count_d;
  logic [GapWidth-1:0]   gap_q;
  logic [GapWidth-1:0]   gap_d;
  logic                  cts_ok;
  logic                  start;

`ifdef UART_TX_SEQ_FLOW_CTRL_EN
  assign cts_ok = ~bus.i_cts_n;
`else
  assign cts_ok = 1'b1;
`endif

  // Pop strobe is combinational so a byte is fetched in the same IDLE cycle;
  // qualified by reset so nothing is popped while held in reset.
  assign start   = i_rst_n && (state_q == IDLE) && bus.i_en && !bus.i_fifo_empty && cts_ok;
  assign count_d = count_q + CountWidth'(1);
  assign gap_d   = gap_q - GapWidth'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SEND;
            data_q  <= bus.i_fifo_rd_data;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          if (bus.i_tx_ready) begin
            count_q <= count_d;
            valid_q <= 1'b0;
            if (GapCycles > 0) begin
              state_q <= GAP;
              gap_q   <= GapWidth'(GapLoad);
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_d;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_fifo_rd_en = start;
  assign bus.o_tx_valid   = valid_q;
  assign bus.o_tx_data    = data_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_tx_count   = count_q;
endmodule

// File: doc/uart_tx_seq.md
# uart_tx_seq

Transmit-side sequencer between the UART TX FIFO and the UART transmitter. It watches the FIFO empty flag and pops one byte at a time into a holding register. It presents that byte to the transmitter over a valid/ready handshake, then enforces a programmable inter-frame gap before fetching the next byte. It is the only agent that drives the TX FIFO read enable.

## Interface
- `DataWidth`, 8, width of one FIFO entry and of the transmitted word
- `GapCycles`, 0, idle clock cycles inserted after each accepted byte (0 = back-to-back)
- `CountWidth`, 16, width of the transmitted-byte counter
- `i_clk`  in  1  system clock, all state on rising edge
- `i_rst_n`  in  1  reset, asynchronous assert, active-low
- `i_en`  in  1  sequencer enable; level-sensitive
- `i_fifo_empty`  in  1  FIFO empty flag
- `i_fifo_rd_data`  in  DataWidth  FIFO entry at current read address (combinational read)
- `o_fifo_rd_en`  out  1  pop strobe to FIFO, one cycle per byte
- `o_tx_valid`  out  1  holding register contains a byte for the transmitter
- `o_tx_data`  out  DataWidth  byte to transmit
- `i_tx_ready`  in  1  transmitter accepts byte when high with `o_tx_valid`
- `o_busy`  out  1  high in any state other than IDLE
- `o_tx_count`  out  CountWidth  bytes accepted by the transmitter since reset
- `i_cts_n`  in  1  clear-to-send, active-low (present only with `UART_TX_SEQ_FLOW_CTRL_EN`)

## Operation
- States: IDLE, SEND, GAP.
- Start condition: state IDLE, `i_en`=1, `i_fifo_empty`=0, and (flow control enabled) `i_cts_n`=0.
- IDLE:
  - On the start condition, assert `o_fifo_rd_en` combinationally in that cycle.
  - Capture `i_fifo_rd_data` into `o_tx_data` at the same edge.
  - Next state is SEND.
- SEND:
  - `o_tx_valid`=1, and `o_tx_data` is held stable.
  - On an edge with `i_tx_ready`=1, the byte is transferred and `o_tx_count` increments.
  - After transfer, go to GAP if `GapCycles`>0, else IDLE.
- GAP:
  - A down-counter loads `GapCycles`-1 on entry and decrements each cycle.
  - Return to IDLE when it reaches 0.
  - `o_tx_valid`=0 throughout.
- `i_en` deassert:
  - Checked only in IDLE.
  - A byte already in SEND/GAP completes normally and is never dropped.
- `o_fifo_rd_en` is never asserted while `i_fifo_empty`=1 and never asserted outside IDLE. At most one byte is outstanding.
- `o_tx_count` wraps from all-ones to 0 without saturation.
- Gap counter width is `$clog2(GapCycles+1)`, minimum 1.

## Timing
- Reset values:
  - State IDLE.
  - `o_tx_valid`=0, `o_tx_data`=0, `o_fifo_rd_en`=0, `o_busy`=0, `o_tx_count`=0, gap counter 0.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous). A popped but unsent byte is lost by design.
- Latency: start condition in cycle N; `o_tx_valid` high in cycle N+1. With `i_tx_ready` held high, transfer occurs at the end of cycle N+1.
- Throughput with `GapCycles`=0 and ready always high: one byte per 2 cycles (IDLE, SEND alternate).
- With gap G: one byte per G+2 cycles.
- `i_fifo_empty` falling in the same cycle as IDLE entry is honoured in that cycle; there is no extra synchroniser stage.
- `i_tx_ready` high while `o_tx_valid`=0 is ignored.

## Configuration
- `UART_TX_SEQ_FLOW_CTRL_EN` defined:
  - `i_cts_n` port exists and gates the start condition.
  - `i_cts_n` is sampled only in IDLE, so a byte in SEND completes even if CTS deasserts.
- Not defined:
  - Port absent; the start condition ignores flow control.

## Test plan
- Reset, FIFO empty, `i_en`=1 for 20 cycles: `o_fifo_rd_en` never asserts, `o_tx_valid`=0, `o_busy`=0, `o_tx_count`=0.
- FIFO holds 0xA5, 0x3C; `GapCycles`=0; `i_tx_ready`=1:
  - Two rd_en pulses 2 cycles apart.
  - `o_tx_data` shows 0xA5 then 0x3C.
  - `o_tx_count`=2.
- FIFO holds 0x55; `i_tx_ready` low for 5 cycles in SEND, then high:
  - `o_tx_valid` stays high with 0x55 stable for 6 cycles.
  - One transfer, `o_tx_count`=1.
- `GapCycles`=3, three bytes queued, ready=1: successive rd_en pulses are exactly 5 cycles apart.
- `i_en` dropped the cycle after a pop:
  - That byte is still transferred.
  - No further rd_en occurs while `i_en`=0 despite a non-empty FIFO.
- Async reset pulsed during SEND with 0x7E pending:
  - `o_tx_valid`, `o_busy` and `o_tx_count` clear without a clock edge.
  - After release, the next FIFO byte is popped normally.
- Flow control:
  - With `UART_TX_SEQ_FLOW_CTRL_EN` and `i_cts_n`=1: no pop.
  - Drop `i_cts_n` to 0: pop occurs in that cycle.
